// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one ready/valid FP adder.
// A tag FIFO remembers which requester owns each in-flight sum, so results are
// steered back in issue order.
//
// Handshakes: a transfer happens on any interface in the cycle where both valid
// and ready are high at the rising edge. A valid, once raised, is not required
// to be held by this block. Ready is never used to qualify valid.
module fp_adder_arbiter #(
   parameter int NREQ      = 4,
   parameter int TAG_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [32*NREQ-1:0]         req_a,
   input  logic [32*NREQ-1:0]         req_b,
   output logic [NREQ-1:0]            resp_valid,
   input  logic [NREQ-1:0]            resp_ready,
   output logic [31:0]                resp_result,
   output logic [31:0]                add_a,
   output logic [31:0]                add_b,
   output logic                       add_valid,
   input  logic                       add_ready,
   input  logic [31:0]                add_result,
   input  logic                       add_valid_out,
   output logic                       add_ready_in,
   output logic [$clog2(TAG_DEPTH):0] outstanding,
   output logic                       err_orphan
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = $clog2(TAG_DEPTH);
   localparam logic [PW:0] DEPTH = (PW+1)'(TAG_DEPTH);

   // Requester index base+k, wrapped modulo NREQ.
   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
      return IW'((int'(base) + k) % NREQ);
   endfunction

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic [IW-1:0] tag_mem_q [TAG_DEPTH];

   logic          found;
   logic [IW-1:0] grant;
   logic [IW-1:0] head;
   logic          full, empty, issue, pop;

   // Grant search, request/response steering and next-state computation.
   always_comb begin
      found        = 1'b0;
      grant        = '0;
      full         = (count_q == DEPTH);
      empty        = (count_q == '0);
      head         = tag_mem_q[rd_ptr_q];
      req_ready    = '0;
      resp_valid   = '0;
      add_a        = '0;
      add_b        = '0;
      resp_result  = add_result;
      rr_ptr_d     = rr_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      err_d        = err_q;

      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[wrap_idx(rr_ptr_q, k)]) begin
            found = 1'b1;
            grant = wrap_idx(rr_ptr_q, k);
         end
      end

      // reset_n gates the request side so nothing is offered while in reset,
      // even if requesters keep their valids high.
      add_valid = reset_n && found && !full;
      issue     = add_valid && add_ready;
      if (add_valid) begin
         add_a = req_a[32*int'(grant) +: 32];
         add_b = req_b[32*int'(grant) +: 32];
      end
      if (issue) begin
         req_ready[grant] = 1'b1;
      end

      // With no tag in flight the adder output is always accepted so a stray
      // result cannot wedge the adder.
      add_ready_in = empty ? 1'b1 : resp_ready[head];
      if (reset_n && !empty && add_valid_out) begin
         resp_valid[head] = 1'b1;
      end
      pop = add_valid_out && add_ready_in && !empty;

      if (issue) begin
         rr_ptr_d = wrap_idx(grant, 1);
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (issue && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!issue && pop) begin
         count_d = count_q - (PW+1)'(1);
      end
      if (add_valid_out && empty) begin
         err_d = 1'b1;
      end
   end

   // Arbitration pointer, FIFO pointers, occupancy and sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Tag storage; contents are only read while the occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (issue) begin
         tag_mem_q[wr_ptr_q] <= grant;
      end
   end

   assign outstanding = count_q;
   assign err_orphan  = err_q;

endmodule

// File: doc/fp_adder_arbiter.md
FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one ready-valid FP adder (legal 2..8).
REQ-002 The block SHALL have parameter TAG_DEPTH, default 8, giving the depth of the in-flight tag FIFO (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester operand accepted.
REQ-007 The block SHALL have port req_a, input, 32*NREQ bits: requester i's operand a in bits [32i+31:32i].
REQ-008 The block SHALL have port req_b, input, 32*NREQ bits: requester i's operand b, same packing as req_a.
REQ-009 The block SHALL have port resp_valid, output, NREQ bits: result valid for requester i.
REQ-010 The block SHALL have port resp_ready, input, NREQ bits: requester i accepts its result.
REQ-011 The block SHALL have port resp_result, output, 32 bits: result shared by all requesters, meaningful only for the requester whose resp_valid is high.
REQ-012 The block SHALL have port add_a / add_b, output, 32 bits each: operands driven to the shared adder.
REQ-013 The block SHALL have port add_valid (output, 1) and add_ready (input, 1): the adder input handshake.
REQ-014 The block SHALL have port add_result (input, 32), add_valid_out (input, 1) and add_ready_in (output, 1): the adder output handshake.
REQ-015 The block SHALL have port outstanding, output, $clog2(TAG_DEPTH)+1 bits: current tag FIFO occupancy.
REQ-016 The block SHALL have port err_orphan, output, 1 bit: sticky flag set when add_valid_out is high while the tag FIFO is empty.

Function
REQ-017 An issue SHALL occur in a cycle when add_valid && add_ready are both high.
REQ-018 add_valid SHALL be high iff at least one req_valid bit is high and outstanding < TAG_DEPTH.
REQ-019 Grant SHALL be round-robin: search starts at rr_ptr, and the first requester with req_valid high at or after rr_ptr (wrapping) wins.
REQ-020 add_a/add_b SHALL carry the granted requester's operands; when none is granted, they SHALL be 0.
REQ-021 req_ready[i] SHALL be high only for the granted i, and only when add_ready is high and outstanding < TAG_DEPTH; all other bits SHALL be 0.
REQ-022 On issue, rr_ptr SHALL become (grant+1) mod NREQ, and the grant index SHALL be pushed at the tag FIFO tail.
REQ-023 With no issue, rr_ptr SHALL hold.
REQ-024 resp_valid[tag_head] SHALL equal add_valid_out when the FIFO is non-empty; all other resp_valid bits SHALL be 0.
REQ-025 resp_result SHALL equal add_result combinationally.
REQ-026 add_ready_in SHALL equal resp_ready[tag_head] when the FIFO is non-empty, and 1 otherwise, so orphans drain.
REQ-027 On add_valid_out && add_ready_in with the FIFO non-empty, the tag at the head SHALL pop.
REQ-028 A push and a pop in the same cycle SHALL leave outstanding unchanged and both pointers advanced.
REQ-029 Pointers SHALL wrap modulo TAG_DEPTH.
REQ-030 Issue when full SHALL be impossible: a same-cycle pop does not free a slot for a push.
REQ-031 err_orphan SHALL set on add_valid_out with the FIFO empty and SHALL clear only on reset.
REQ-032 There SHALL be no added latency: request-to-adder and adder-to-response paths are combinational; FIFO state updates next edge.
REQ-033 A held response SHALL not block issue to the adder: the adder's own backpressure governs add_ready.

Reset
REQ-034 While reset_n is low: rr_ptr=0, FIFO pointers=0, outstanding=0, err_orphan=0; req_ready=0, resp_valid=0, add_valid=0.
REQ-035 Reset mid-operation SHALL discard all tags; the adder SHALL be reset by the same reset_n, so in-flight results are lost by design.
REQ-036 Reset release SHALL be synchronised externally; the first issue may occur on the first edge with reset_n high.

Verification
REQ-037 All req_valid=1 continuously, add_ready=1, resp_ready=1: grants SHALL be 0,1,2,3,0,... and each requester SHALL receive its own sums in order (e.g. requester 2 sends 1.0+2.0 and gets 0x40400000).
REQ-038 Only requester 3 valid after a grant to 1: requester 3 SHALL be granted next cycle, then rr_ptr=0.
REQ-039 resp_ready=0 held for 8 issues with TAG_DEPTH=8: outstanding SHALL reach 8, add_valid SHALL drop, and no issue SHALL occur until a pop; a pop with push-pending SHALL issue the cycle after.
REQ-040 Responses for requesters 0 and 1 interleaved with resp_ready[1]=0: requester 1's result SHALL stall the adder output, with no loss or reordering.
REQ-041 Inject add_valid_out=1 with outstanding=0: err_orphan SHALL go 1, add_ready_in SHALL be 1, and no resp_valid SHALL assert.
REQ-042 Assert reset_n=0 with outstanding=5: all outputs SHALL be at reset values within the same cycle, outstanding SHALL be 0 after release, and grant SHALL restart at requester 0.
